// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA timing constants, FSM state encoding and coordinate helpers
// for the sync decoder (same timing set as the pixel address generator).
package vga_sync_decoder_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Timing set selected by a VGA_MODE_* define; 640x480@60 is the default.
`ifdef VGA_MODE_640X400
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 400;
  localparam int VGA_V_FRONT   = 12;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 35;
`else
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
`endif

  // Lock FSM encoding
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_H_LOCK = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Increment a coordinate, wrapping to zero after the last value
  function automatic coord_t wrap_inc(input coord_t value, input coord_t last);
    return (value == last) ? '0 : value + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Sync input / decoded coordinate bundle between a VGA source and the decoder.
interface vga_sync_decoder_if;
  import vga_sync_decoder_pkg::*;

  logic   enable;
  logic   hsync;
  logic   vsync;
  coord_t column;
  coord_t row;
  logic   visible;
  logic   locked;
  logic   error;

  modport master (
    output enable, hsync, vsync,
    input  column, row, visible, locked, error
  );

  modport slave (
    input  enable, hsync, vsync,
    output column, row, visible, locked, error
  );
endinterface

// File: rtl/vga_sync_edge.sv
// Polarity-corrected sync history and start-edge detector.
module vga_sync_edge #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sync_in,
  output logic start_pulse
);

  logic active;
  logic prev_active_q, prev_active_d;

  assign active = (sync_in == POL);

  // History only advances on enabled samples
  always_comb begin
    prev_active_d = enable ? active : prev_active_q;
  end

  // History resets to "active" so a sync already asserted at reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (reset) prev_active_q <= 1'b1;
    else       prev_active_q <= prev_active_d;
  end

  assign start_pulse = enable && active && !prev_active_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers column/row from incoming hsync/vsync and tracks lock status.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input logic           clk,
  input logic           reset,
  vga_sync_decoder_if.slave bus
);

  localparam coord_t H_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_SS    = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t V_SS    = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);

  logic       h_start, v_start;
  coord_t     pc, pr;
  coord_t     column_q, column_d;
  coord_t     row_q, row_d;
  logic [1:0] state_q, state_d;
  logic       error_q, error_d;
  logic       h_misaligned;

  vga_sync_edge #(.POL(HSYNC_POL)) u_h_edge (
    .clk         (clk),
    .reset       (reset),
    .enable      (bus.enable),
    .sync_in     (bus.hsync),
    .start_pulse (h_start)
  );

  vga_sync_edge #(.POL(VSYNC_POL)) u_v_edge (
    .clk         (clk),
    .reset       (reset),
    .enable      (bus.enable),
    .sync_in     (bus.vsync),
    .start_pulse (v_start)
  );

  // Predict next position, apply sync overrides and step the lock FSM
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    column_d     = column_q;
    row_d        = row_q;
    state_d      = state_q;
    error_d      = 1'b0;
    pc           = wrap_inc(column_q, H_LAST);
    pr           = (column_q == H_LAST) ? wrap_inc(row_q, V_LAST) : row_q;
    h_misaligned = h_start && (pc != H_SS);

    if (bus.enable) begin
      column_d = h_start ? H_SS : pc;
      row_d    = v_start ? V_SS : pr;

      case (state_q)
        ST_SEARCH: begin
          if (h_start) state_d = ST_H_LOCK;
        end
        ST_H_LOCK: begin
          // A coincident h/v edge always fails one of the two position tests
          if (h_misaligned || (v_start && pc != '0)) error_d = 1'b1;
          else if (v_start)                          state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (h_misaligned || (v_start && (pc != '0 || pr != V_SS))) begin
            error_d = 1'b1;
            state_d = ST_H_LOCK;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // Coordinate, state and error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      column_q <= '0;
      row_q    <= '0;
      state_q  <= ST_SEARCH;
      error_q  <= 1'b0;
    end else begin
      column_q <= column_d;
      row_q    <= row_d;
      state_q  <= state_d;
      error_q  <= error_d;
    end
  end

  assign bus.column  = column_q;
  assign bus.row     = row_q;
  assign bus.locked  = (state_q == ST_LOCKED);
  assign bus.visible = (state_q == ST_LOCKED) && (column_q < H_VIS_C) && (row_q < V_VIS_C);
  assign bus.error   = error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed testbench for vga_sync_decoder driven by a small 640x480 sync model.
module tb_vga_sync_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sync_decoder_if vif ();

  vga_sync_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif.slave)
  );

  int checks = 0;
  int errors = 0;
  int gen_col, gen_row;   // position the model drives next
  int s_col, s_row;       // position of the most recent sample
  bit error_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive active-low syncs for the model position, clock it, then advance
  task automatic gen_step();
    vif.hsync = (gen_col >= 656 && gen_col < 752) ? 1'b0 : 1'b1;
    vif.vsync = (gen_row >= 490 && gen_row < 492) ? 1'b0 : 1'b1;
    tick();
    s_col = gen_col;
    s_row = gen_row;
    if (vif.error) error_seen = 1'b1;
    if (gen_col == 799) begin
      gen_col = 0;
      gen_row = (gen_row == 524) ? 0 : gen_row + 1;
    end else begin
      gen_col = gen_col + 1;
    end
  endtask

  task automatic gen_steps(input int n);
    for (int i = 0; i < n; i++) gen_step();
  endtask

  task automatic test_reset();
    reset = 1'b1; vif.enable = 1'b1; vif.hsync = 1'b0; vif.vsync = 1'b0;
    tick(); tick();
    checks++; if (vif.column !== 10'd0) begin errors++; $display("FAIL reset_column got %0d want 0", vif.column); end
    checks++; if (vif.row !== 10'd0) begin errors++; $display("FAIL reset_row got %0d want 0", vif.row); end
    checks++; if ({vif.locked, vif.visible, vif.error} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {vif.locked, vif.visible, vif.error}); end
    reset = 1'b0;
    tick();
    // Syncs held active through reset: no edge, so the column just counts
    checks++; if (vif.column !== 10'd1) begin errors++; $display("FAIL reset_no_edge_column got %0d want 1", vif.column); end
    checks++; if (vif.row !== 10'd0 || vif.error !== 1'b0) begin
      errors++; $display("FAIL reset_no_edge_row_err got row %0d err %b want 0 0", vif.row, vif.error); end
  endtask

  task automatic test_acquisition();
    vif.hsync = 1'b1; vif.vsync = 1'b1;
    tick(); tick(); tick();
    gen_col = 656; gen_row = 0; error_seen = 1'b0;
    gen_step();
    checks++; if (vif.column !== 10'd656) begin errors++; $display("FAIL acq_column got %0d want 656", vif.column); end
    checks++; if (vif.row !== 10'd0 || vif.error !== 1'b0) begin
      errors++; $display("FAIL acq_row_err got row %0d err %b want 0 0", vif.row, vif.error); end
    gen_steps(144);
    checks++; if (vif.column !== 10'd0 || vif.row !== 10'd1) begin
      errors++; $display("FAIL acq_wrap got (%0d,%0d) want (0,1)", vif.column, vif.row); end
    checks++; if (error_seen || vif.locked !== 1'b0) begin
      errors++; $display("FAIL acq_status got err_seen %b locked %b want 0 0", error_seen, vif.locked); end
  endtask

  task automatic test_frame_lock();
    gen_steps(799);           // finish line 1; next sample is column 0
    gen_row = 490;            // jump the source to its vsync line
    gen_step();
    checks++; if (vif.column !== 10'd0 || vif.row !== 10'd490) begin
      errors++; $display("FAIL lock_pos got (%0d,%0d) want (0,490)", vif.column, vif.row); end
    checks++; if (vif.locked !== 1'b1 || vif.visible !== 1'b0 || vif.error !== 1'b0) begin
      errors++; $display("FAIL lock_flags got locked %b vis %b err %b want 1 0 0", vif.locked, vif.visible, vif.error); end
    error_seen = 1'b0;
    gen_steps(35 * 800);
    checks++; if (vif.column !== 10'd0 || vif.row !== 10'd0 || vif.visible !== 1'b1) begin
      errors++; $display("FAIL lock_frame_wrap got (%0d,%0d) vis %b want (0,0) 1", vif.column, vif.row, vif.visible); end
    checks++; if (error_seen || vif.locked !== 1'b1) begin
      errors++; $display("FAIL lock_hold got err_seen %b locked %b want 0 1", error_seen, vif.locked); end
    gen_steps(639);
    checks++; if (vif.column !== 10'd639 || vif.visible !== 1'b1) begin
      errors++; $display("FAIL vis_639 got col %0d vis %b want 639 1", vif.column, vif.visible); end
    gen_step();
    checks++; if (vif.column !== 10'd640 || vif.visible !== 1'b0) begin
      errors++; $display("FAIL vis_640 got col %0d vis %b want 640 0", vif.column, vif.visible); end
  endtask

  task automatic test_misalignment();
    gen_steps(5);             // samples 641..645
    gen_col = 656;            // hsync arrives 10 columns early (pc == 646)
    gen_step();
    checks++; if (vif.error !== 1'b1 || vif.column !== 10'd656 || vif.locked !== 1'b0) begin
      errors++; $display("FAIL misalign_hit got err %b col %0d locked %b want 1 656 0", vif.error, vif.column, vif.locked); end
    gen_step();
    checks++; if (vif.error !== 1'b0 || vif.column !== 10'd657) begin
      errors++; $display("FAIL misalign_pulse got err %b col %0d want 0 657", vif.error, vif.column); end
    gen_steps(142);           // samples 658..799
    gen_row = 490;
    gen_step();
    checks++; if (vif.locked !== 1'b1 || vif.error !== 1'b0 || vif.row !== 10'd490 || vif.column !== 10'd0) begin
      errors++; $display("FAIL relock got locked %b err %b (%0d,%0d) want 1 0 (0,490)", vif.locked, vif.error, vif.column, vif.row); end
  endtask

  task automatic test_enable_gating();
    gen_steps(100);
    vif.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vif.hsync = i[0];       // toggle hsync: gated edges must not count
      vif.vsync = 1'b1;       // vsync inactive while the held history says active
      tick();
      checks++; if (vif.column !== 10'd100 || vif.row !== 10'd490 || vif.error !== 1'b0) begin
        errors++; $display("FAIL gate_hold_%0d got (%0d,%0d) err %b want (100,490) 0", i, vif.column, vif.row, vif.error); end
    end
    vif.enable = 1'b1;
    gen_step();
    checks++; if (vif.column !== 10'd101 || vif.error !== 1'b0 || vif.locked !== 1'b1) begin
      errors++; $display("FAIL gate_resume got col %0d err %b locked %b want 101 0 1", vif.column, vif.error, vif.locked); end
  endtask

  task automatic test_full_track();
    int bad = 0;
    int f_gc = 0, f_gr = 0, f_dc = 0, f_dr = 0;
    for (int i = 0; i < 30000; i++) begin
      gen_step();
      if (vif.column !== 10'(s_col) || vif.row !== 10'(s_row) || vif.locked !== 1'b1 ||
          vif.error !== 1'b0 || vif.visible !== (s_col < 640 && s_row < 480)) begin
        if (bad == 0) begin
          f_gc = s_col; f_gr = s_row; f_dc = int'(vif.column); f_dr = int'(vif.row);
        end
        bad++;
      end
    end
    checks++; if (bad !== 0) begin
      errors++;
      $display("FAIL full_track got %0d bad cycles (first: decoded (%0d,%0d) source (%0d,%0d)) want 0",
               bad, f_dc, f_dr, f_gc, f_gr);
    end
  endtask

  initial begin
    test_reset();
    test_acquisition();
    test_frame_lock();
    test_misalignment();
    test_enable_gating();
    test_full_track();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
